// File: rtl/dac_sample_sequencer_if.sv
// Producer-side sample handshake for the DAC sample sequencer: two valid/ready/data channels.
interface dac_sample_sequencer_if #(
    parameter int DW = 10
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/dac_sample_sequencer.sv
// Two producers -> round-robin arbiter -> sample FIFO -> rate-divided playback onto the DAC code bus.
//  state | meaning
//  IDLE  | playback off, divider parked at 0, FIFO contents kept
//  PRIME | waiting for FIFO level to reach PRIME before playback
//  RUN   | divider counts down; each terminal count pops one sample
module dac_sample_sequencer #(
    parameter int DW    = 10,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16,
    parameter int PRIME = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic [DIV_W-1:0]         div,
    dac_sample_sequencer_if.slave    prod,
    output logic [DW-1:0]            dac_d,
    output logic                     dac_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    input  logic                     clr_underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_C = (AW+1)'(PRIME);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             rr_last;
    logic             ready0, ready1;
    logic             grant0, grant1;
    logic             push, pop, tick;
    logic             full, empty;
    logic [DW-1:0]    wdata;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign fifo_level = count;

    // Readies only ever rise for a valid requester; on a tie the one not served last wins.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!reset && !full) begin
            if (prod.req0_valid && prod.req1_valid) begin
                ready0 = rr_last;
                ready1 = !rr_last;
            end else begin
                ready0 = prod.req0_valid;
                ready1 = prod.req1_valid;
            end
        end
    end

    assign prod.req0_ready = ready0;
    assign prod.req1_ready = ready1;
    assign grant0          = prod.req0_valid && ready0;
    assign grant1          = prod.req1_valid && ready1;
    assign push            = grant0 || grant1;
    assign wdata           = grant0 ? prod.req0_data : prod.req1_data;

    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        tick       = 1'b0;
        case (state)
            S_IDLE: begin
                div_next = '0;
                if (en) state_next = S_PRIME;
            end
            S_PRIME: begin
                div_next = '0;
                if (!en) begin
                    state_next = S_IDLE;
                end else if (count >= PRIME_C) begin
                    state_next = S_RUN;
                    div_next   = div;
                end
            end
            S_RUN: begin
                tick     = (div_cnt == '0);
                div_next = tick ? div : div_cnt - DIV_W'(1);
                if (!en) begin
                    state_next = S_IDLE;
                    div_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                div_next   = '0;
            end
        endcase
    end

    assign pop = tick && !empty;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr_last    <= 1'b1;
            dac_d      <= '0;
            dac_update <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            dac_update <= pop;
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                rr_last <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                dac_d  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // An empty tick sets the flag even when a clear arrives in the same cycle.
            if (tick && empty)     underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Scoreboard bench: accepted writes are queued in order and compared against each dac_update.
module tb_dac_sample_sequencer;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        clr_underrun = 1'b0;
    logic [15:0] div = '0;
    logic [9:0]  dac_d;
    logic        dac_update;
    logic [3:0]  fifo_level;
    logic        underrun;

    dac_sample_sequencer_if #(.DW(10)) bus ();

    dac_sample_sequencer #(.DW(10), .DEPTH(8), .DIV_W(16), .PRIME(4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .en           (en),
        .div          (div),
        .prod         (bus),
        .dac_d        (dac_d),
        .dac_update   (dac_update),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 CLK = ~CLK;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         upd_cnt = 0;
    logic [9:0] exp_q [$];
    int         id_q [$];
    int         upd_t [$];
    logic [9:0] exp_head;
    logic [9:0] d0, d1;
    logic       a0, a1;
    int         n, b, base, u;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (dac_update) begin
            upd_cnt++;
            upd_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_spurious_update", 1, 0);
            end else begin
                exp_head = exp_q.pop_front();
                check("sb_data", dac_d, exp_head);
            end
        end
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.req0_valid && bus.req1_valid)
                check("one_ready", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back(bus.req0_data);
                id_q.push_back(0);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back(bus.req1_data);
                id_q.push_back(1);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic send0(input logic [9:0] d);
        int w;
        w = 0;
        bus.req0_data  = d;
        bus.req0_valid = 1'b1;
        @(negedge CLK);
        while (!bus.req0_ready && w < 100) begin
            w++;
            @(negedge CLK);
        end
        if (w >= 100) check("send_timeout", 0, 1);
        @(posedge CLK);
        #1;
        bus.req0_valid = 1'b0;
    endtask

    task automatic wait_upd(input int k, input int budget);
        int target, c;
        target = upd_cnt + k;
        c = 0;
        while (upd_cnt < target && c < budget) begin
            @(posedge CLK);
            c++;
        end
        if (upd_cnt < target) check("update_timeout", upd_cnt, target);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with both producers asserting valid
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 10'h111;
        bus.req1_data  = 10'h222;
        repeat (3) begin
            @(negedge CLK);
            check("rst_dac_d", dac_d, 0);
            check("rst_level", fifo_level, 0);
            check("rst_underrun", underrun, 0);
            check("rst_update", dac_update, 0);
            check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end
        @(posedge CLK);
        #1;
        reset = 1'b0;

        // T3: both producers valid continuously while playback drains
        en = 1'b1;
        div = 16'd1;
        d0 = 10'h100;
        d1 = 10'h200;
        bus.req0_data = d0;
        bus.req1_data = d1;
        base = id_q.size();
        n = 0;
        b = 0;
        while (n < 12 && b < 300) begin
            @(negedge CLK);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge CLK);
            #1;
            if (a0) begin d0 = d0 + 10'd1; bus.req0_data = d0; n++; end
            if (a1) begin d1 = d1 + 10'd1; bus.req1_data = d1; n++; end
            b++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("rr_accepts", n, 12);
        if (id_q.size() >= base + 12)
            for (int i = 0; i < 12; i++) check("rr_order", id_q[base+i], i % 2);
        b = 0;
        @(negedge CLK);
        while (fifo_level != 0 && b < 200) begin
            b++;
            @(negedge CLK);
        end
        check("t3_drain_level", fifo_level, 0);
        step(4);
        check("t3_sb_empty", exp_q.size(), 0);

        en = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // T2: rate divider, div=3 -> one update every 4 cycles
        div = 16'd3;
        en = 1'b1;
        base = upd_t.size();
        send0(10'h000);
        send0(10'h155);
        send0(10'h2AA);
        send0(10'h3FF);
        wait_upd(4, 100);
        if (upd_t.size() >= base + 4)
            for (int i = 1; i < 4; i++) check("t2_period", upd_t[base+i] - upd_t[base+i-1], 4);
        check("t2_last", dac_d, 10'h3FF);

        // T4: fill to full while idle, then play back intact
        en = 1'b0;
        step(2);
        for (int i = 0; i < 8; i++) send0(10'(16 + i));
        @(negedge CLK);
        check("t4_level", fifo_level, 8);
        @(posedge CLK);
        #1;
        bus.req0_data  = 10'h3C3;
        bus.req0_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("t4_full_ready", bus.req0_ready, 0);
        end
        @(posedge CLK);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge CLK);
        check("t4_level_hold", fifo_level, 8);
        @(posedge CLK);
        #1;
        div = 16'd1;
        en = 1'b1;
        wait_upd(8, 200);

        // T5: underrun with producers stopped
        step(6);
        @(negedge CLK);
        check("t5_hold", dac_d, 10'h017);
        check("t5_underrun", underrun, 1);
        u = upd_cnt;
        step(10);
        check("t5_no_update", upd_cnt, u);
        div = 16'd0;
        step(3);
        clr_underrun = 1'b1;
        step(1);
        clr_underrun = 1'b0;
        @(negedge CLK);
        check("t5_clr_vs_tick", underrun, 1);
        @(posedge CLK);
        #1;
        en = 1'b0;
        step(2);
        clr_underrun = 1'b1;
        step(1);
        clr_underrun = 1'b0;
        @(negedge CLK);
        check("t5_clr", underrun, 0);
        @(posedge CLK);
        #1;

        // T6: reset during RUN with five samples queued
        div = 16'd50;
        en = 1'b1;
        u = upd_cnt;
        for (int i = 0; i < 5; i++) send0(10'(176 + i));
        @(negedge CLK);
        check("t6_pre_level", fifo_level, 5);
        check("t6_pre_no_update", upd_cnt, u);
        check("t6_pre_dac", dac_d, 10'h017);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge CLK);
        check("t6_level", fifo_level, 0);
        check("t6_dac_d", dac_d, 0);
        check("t6_update", dac_update, 0);
        @(posedge CLK);
        #1;
        div = 16'd1;
        u = upd_cnt;
        send0(10'h0C0);
        send0(10'h0C1);
        send0(10'h0C2);
        step(20);
        check("t6_prime_wait", upd_cnt, u);
        send0(10'h0C3);
        wait_upd(4, 100);
        check("t6_last", dac_d, 10'h0C3);
        step(4);
        check("sb_empty_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
